// File: rtl/backscatter_pkg.sv
// Shared types and helpers for the backscatter modulator.
package backscatter_pkg;

   typedef enum logic [1:0] {StIdle, StDelay, StSend} state_e;

   localparam int unsigned RATE_W = 2;

   function automatic int unsigned cycles_per_bit(input int unsigned symbol_cycles,
                                                  input logic [RATE_W-1:0] rate);
      return symbol_cycles << rate;
   endfunction

endpackage

// File: rtl/trigger_sync_edge.sv
// Two-flop synchroniser for the excitation trigger plus a registered rising-edge pulse.
module trigger_sync_edge (
   input  logic clock,
   input  logic reset,
   input  logic trigger_signal,
   output logic start
);

   logic sync1_q, sync2_q, hist_q, start_q;
   logic start_d;

   always_comb start_d = sync2_q & ~hist_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= 1'b0;
         start_q <= 1'b0;
      end else begin
         sync1_q <= trigger_signal;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
         start_q <= start_d;
      end
   end

   assign start = start_q;

endmodule

// File: rtl/backscatter_modulator.sv
// Backscatter modulator: after a trigger and start delay, shifts data words out LSB first as
// phase flips on a frequency-shift square wave, at a bit rate latched at trigger time.
module backscatter_modulator
   import backscatter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned SHIFT_HALF    = 2,
   parameter int unsigned SYMBOL_CYCLES = 100,
   parameter int unsigned START_DELAY   = 192,
   parameter int unsigned CNT_WIDTH     = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  trigger_signal,
   input  logic [RATE_W-1:0]     rate_sel,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  clock_out,
   output logic                  signal_into_switch,
   output logic [RATE_W-1:0]     output_data_rate,
   output logic                  busy
);

   localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(DATA_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] DELAY_LOAD = CNT_WIDTH'(START_DELAY - 1);
   localparam logic [CNT_WIDTH-1:0] PHASE_LOAD = CNT_WIDTH'(SHIFT_HALF - 1);

   state_e                state_q, state_d;
   logic [CNT_WIDTH-1:0]  delay_cnt_q, delay_cnt_d;
   logic [CNT_WIDTH-1:0]  phase_cnt_q, phase_cnt_d;
   logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
   logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [RATE_W-1:0]     rate_q, rate_d;
   logic                  clock_out_q, clock_out_d;
   logic                  sis_q, sis_d;
   logic                  busy_q, busy_d;
   logic                  start, delay_last, bit_last, word_last;
   logic [CNT_WIDTH-1:0]  bit_load;

   trigger_sync_edge u_trigger_sync_edge (
      .clock          (clock),
      .reset          (reset),
      .trigger_signal (trigger_signal),
      .start          (start)
   );

   assign bit_load   = CNT_WIDTH'(cycles_per_bit(SYMBOL_CYCLES, rate_q) - 1);
   assign delay_last = (delay_cnt_q == '0);
   assign bit_last   = (bit_cnt_q == '0);
   assign word_last  = bit_last && (bit_idx_q == LAST_IDX);

   always_comb begin
      state_d     = state_q;
      delay_cnt_d = delay_cnt_q;
      phase_cnt_d = phase_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      rate_d      = rate_q;
      clock_out_d = 1'b0;
      in_ready    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               rate_d      = rate_sel;
               delay_cnt_d = DELAY_LOAD;
               state_d     = StDelay;
            end
         end
         StDelay: begin
            delay_cnt_d = delay_cnt_q - CNT_WIDTH'(1);
            if (delay_last) begin
               if (in_valid) begin
                  in_ready    = 1'b1;
                  shift_d     = in_data;
                  bit_idx_d   = '0;
                  bit_cnt_d   = bit_load;
                  phase_cnt_d = PHASE_LOAD;
                  clock_out_d = 1'b1;
                  state_d     = StSend;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StSend: begin
            // The wave free-runs across word boundaries; only leaving SEND stops it.
            if (phase_cnt_q == '0) begin
               phase_cnt_d = PHASE_LOAD;
               clock_out_d = ~clock_out_q;
            end else begin
               phase_cnt_d = phase_cnt_q - CNT_WIDTH'(1);
               clock_out_d = clock_out_q;
            end
            if (word_last) begin
               if (in_valid) begin
                  in_ready  = 1'b1;
                  shift_d   = in_data;
                  bit_idx_d = '0;
                  bit_cnt_d = bit_load;
               end else begin
                  state_d     = StIdle;
                  clock_out_d = 1'b0;
               end
            end else if (bit_last) begin
               shift_d   = shift_q >> 1;
               bit_idx_d = bit_idx_q + IDX_W'(1);
               bit_cnt_d = bit_load;
            end else begin
               bit_cnt_d = bit_cnt_q - CNT_WIDTH'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // Switch drive is built from next-state values so wave and phase line up in one cycle.
      sis_d  = (state_d == StSend) ? (clock_out_d ^ shift_d[0]) : 1'b0;
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         delay_cnt_q <= '0;
         phase_cnt_q <= '0;
         bit_cnt_q   <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         rate_q      <= '0;
         clock_out_q <= 1'b0;
         sis_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         delay_cnt_q <= delay_cnt_d;
         phase_cnt_q <= phase_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         rate_q      <= rate_d;
         clock_out_q <= clock_out_d;
         sis_q       <= sis_d;
         busy_q      <= busy_d;
      end
   end

   assign clock_out          = clock_out_q;
   assign signal_into_switch = sis_q;
   assign output_data_rate   = rate_q;
   assign busy               = busy_q;

endmodule

// File: tb/tb_backscatter_modulator.sv
// Bench for backscatter_modulator: timeline model of packets checked every cycle, plus
// directed scenarios with hand-computed counts and bit patterns.
module tb_backscatter_modulator;

   localparam int unsigned DW = 8;
   localparam int unsigned SH = 2;
   localparam int unsigned SC = 4;
   localparam int unsigned SD = 10;
   localparam int unsigned CW = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          trigger_signal;
   logic [1:0]    rate_sel;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          clock_out;
   logic          signal_into_switch;
   logic [1:0]    output_data_rate;
   logic          busy;

   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] src_q[$];
   bit            hs_pend = 1'b0;

   bit            m_active = 1'b0;
   int            m_t = 0;
   logic [DW-1:0] m_word = '0;
   logic [1:0]    m_rate = '0;
   logic [3:0]    m_th = '0;

   int mon_busy, mon_rdy, mon_sis;
   int xq[$];

   backscatter_modulator #(
      .DATA_WIDTH    (DW),
      .SHIFT_HALF    (SH),
      .SYMBOL_CYCLES (SC),
      .START_DELAY   (SD),
      .CNT_WIDTH     (CW)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .trigger_signal     (trigger_signal),
      .rate_sel           (rate_sel),
      .in_data            (in_data),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .clock_out          (clock_out),
      .signal_into_switch (signal_into_switch),
      .output_data_rate   (output_data_rate),
      .busy               (busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, act, exp);
      end
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic pulse();
      trigger_signal = 1'b1;
      run(2);
      trigger_signal = 1'b0;
   endtask

   task automatic mon_clear();
      mon_busy = 0;
      mon_rdy  = 0;
      mon_sis  = 0;
      xq.delete();
   endtask

   function automatic int xbit(input int idx);
      if (idx < xq.size()) return xq[idx];
      return -1;
   endfunction

   // Phase-flip flags taken at the first cycle of each bit rebuild the word that was sent.
   task automatic chk_bits(input string nm, input int cpb, input int expv);
      int v;
      v = 0;
      for (int b = 0; b < int'(DW); b++) begin
         if (xbit(int'(SD) + b * cpb) == 1) v |= (1 << b);
      end
      chk(nm, v, expv);
   endtask

   // Source: presents the queue head, retires it after an observed handshake.
   always @(posedge clock) begin
      #2;
      if (hs_pend) begin
         if (src_q.size() > 0) src_q.delete(0);
         hs_pend = 1'b0;
      end
      in_valid = (src_q.size() > 0);
      in_data  = in_valid ? src_q[0] : '0;
   end

   // Model: a packet is a timeline of SD delay cycles then words of DW*cpb cycles each.
   always @(negedge clock) begin : cmp
      int   cpb, wlen, n, pos, bidx;
      logic e_co, e_sis, e_rdy, boundary;
      if (reset) begin
         chk("rst_busy", int'(busy), 0);
         chk("rst_clock_out", int'(clock_out), 0);
         chk("rst_sis", int'(signal_into_switch), 0);
         chk("rst_in_ready", int'(in_ready), 0);
         chk("rst_rate", int'(output_data_rate), 0);
         m_active = 1'b0;
         m_rate   = '0;
         m_th     = '0;
         hs_pend  = 1'b0;
      end else begin
         cpb      = int'(SC) << m_rate;
         wlen     = int'(DW) * cpb;
         e_co     = 1'b0;
         e_sis    = 1'b0;
         e_rdy    = 1'b0;
         boundary = 1'b0;
         if (m_active) begin
            if (m_t < int'(SD)) begin
               boundary = (m_t == int'(SD) - 1);
            end else begin
               n        = m_t - int'(SD);
               pos      = n % wlen;
               bidx     = pos / cpb;
               e_co     = ((n / int'(SH)) % 2) == 0;
               e_sis    = e_co ^ m_word[bidx];
               boundary = (pos == wlen - 1);
            end
            e_rdy = boundary && in_valid;
         end
         chk("busy", int'(busy), int'(m_active));
         chk("clock_out", int'(clock_out), int'(e_co));
         chk("sis", int'(signal_into_switch), int'(e_sis));
         chk("in_ready", int'(in_ready), int'(e_rdy));
         chk("rate", int'(output_data_rate), int'(m_rate));

         if (busy) begin
            mon_busy++;
            xq.push_back(int'(signal_into_switch ^ clock_out));
         end
         if (in_ready) mon_rdy++;
         if (signal_into_switch) mon_sis++;
         hs_pend = in_valid && in_ready;

         if (m_active) begin
            if (boundary) begin
               if (in_valid) begin
                  m_word = in_data;
                  m_t++;
               end else begin
                  m_active = 1'b0;
               end
            end else begin
               m_t++;
            end
         end else if (m_th[2] && !m_th[3]) begin
            m_active = 1'b1;
            m_t      = 0;
            m_rate   = rate_sel;
         end
         m_th = {m_th[2:0], trigger_signal};
      end
   end

   initial begin
      reset          = 1'b1;
      trigger_signal = 1'b1;
      rate_sel       = 2'd0;
      in_valid       = 1'b0;
      in_data        = '0;
      mon_clear();
      src_q.push_back(8'hA5);
      run(3);
      chk("reset_busy", int'(busy), 0);
      chk("reset_sis", int'(signal_into_switch), 0);
      reset = 1'b0;

      // Trigger held high from reset: one packet of 32 SEND cycles
      run(60);
      chk("t1_busy_cycles", mon_busy, int'(SD) + 32);
      chk("t1_ready_pulses", mon_rdy, 1);
      chk_bits("t1_phase_flips", 4, 'hA5);
      chk("t1_idle", int'(busy), 0);

      // Rate 3: 32 cycles per bit
      trigger_signal = 1'b0;
      run(4);
      mon_clear();
      rate_sel = 2'd3;
      src_q.push_back(8'hA5);
      trigger_signal = 1'b1;
      run(2);
      trigger_signal = 1'b0;
      run(4);
      rate_sel = 2'd1;
      run(3 + int'(SD) + 256 + 10);
      chk("t2_busy_cycles", mon_busy, int'(SD) + 256);
      chk("t2_ready_pulses", mon_rdy, 1);
      chk("t2_rate_held", int'(output_data_rate), 3);
      chk_bits("t2_phase_flips", 32, 'hA5);
      chk("t2_bit0_last", xbit(int'(SD) + 31), 1);
      chk("t2_bit1_first", xbit(int'(SD) + 32), 0);

      // Back-to-back words
      rate_sel = 2'd0;
      mon_clear();
      src_q.push_back(8'hFF);
      src_q.push_back(8'h00);
      pulse();
      run(3 + int'(SD) + 64 + 10);
      chk("t3_ready_pulses", mon_rdy, 2);
      chk("t3_busy_cycles", mon_busy, int'(SD) + 64);
      begin
         int good;
         good = 0;
         for (int i = 0; i < 64; i++) begin
            if (xbit(int'(SD) + i) == ((i < 32) ? 1 : 0)) good++;
         end
         chk("t3_inv_then_true", good, 64);
      end

      // Underrun
      mon_clear();
      pulse();
      run(30);
      chk("t4_busy_cycles", mon_busy, int'(SD));
      chk("t4_ready_pulses", mon_rdy, 0);
      chk("t4_sis_high", mon_sis, 0);

      // Re-trigger during SEND is ignored; after IDLE it starts a new packet
      mon_clear();
      src_q.push_back(8'hA5);
      pulse();
      run(15);
      pulse();
      run(40);
      chk("t5_busy_cycles", mon_busy, int'(SD) + 32);
      chk("t5_ready_pulses", mon_rdy, 1);
      mon_clear();
      src_q.push_back(8'h5A);
      pulse();
      run(60);
      chk("t5_new_busy", mon_busy, int'(SD) + 32);
      chk_bits("t5_new_flips", 4, 'h5A);

      // Reset mid-SEND at bit 3 (rate 1: 8 cycles per bit)
      rate_sel = 2'd1;
      mon_clear();
      src_q.push_back(8'hA5);
      pulse();
      run(38);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_async_busy", int'(busy), 0);
      chk("t6_async_clock_out", int'(clock_out), 0);
      chk("t6_async_sis", int'(signal_into_switch), 0);
      chk("t6_async_rate", int'(output_data_rate), 0);
      run(2);
      reset = 1'b0;
      mon_clear();
      run(40);
      chk("t6_no_resume", mon_busy, 0);
      chk("t6_no_sis", mon_sis, 0);
      rate_sel = 2'd0;
      src_q.push_back(8'hC3);
      pulse();
      run(60);
      chk("t6_new_busy", mon_busy, int'(SD) + 32);
      chk("t6_new_ready", mon_rdy, 1);
      chk_bits("t6_new_flips", 4, 'hC3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/backscatter_modulator.md
# backscatter_modulator

Parametrised codeword-translation modulator driving the RF switch of the backscatter tag. On a detected excitation trigger it waits out the packet preamble, then converts queued data words into a frequency-shifted square wave whose phase is flipped per data bit, at a run-time-selectable bit rate. It sits between the tag data source and the `signal_into_switch` pad, replacing the fixed-rate single-mode modulator in `top`.

## Interface
- `DATA_WIDTH`, 8: bits per input word, shifted out LSB first.
- `SHIFT_HALF`, 2: clock cycles per half-period of the frequency-shift wave (≥1).
- `SYMBOL_CYCLES`, 100: clock cycles per excitation symbol (1 µs at 100 MHz, ≥1).
- `START_DELAY`, 192: clock cycles from trigger detection to first bit (≥1).
- `CNT_WIDTH`, 16: width of the delay and symbol counters. Must hold `START_DELAY` and `SYMBOL_CYCLES*8`.
- `clock` in 1: system clock. This is the block's one clock.
- `reset` in 1: asynchronous, active-high reset.
- `trigger_signal` in 1: asynchronous excitation-detect input.
- `rate_sel` in 2: symbols per bit = 1 << rate_sel (1, 2, 4, 8).
- `in_data` in DATA_WIDTH: data word.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: one-cycle accept pulse; a word transfers when `in_valid && in_ready`.
- `clock_out` out 1: frequency-shift wave. Runs only in SEND, otherwise 0.
- `signal_into_switch` out 1: `clock_out ^ cur_bit` in SEND, otherwise 0.
- `output_data_rate` out 2: `rate_sel` latched at trigger detection.
- `busy` out 1: high in DELAY and SEND.

## Operation
- `trigger_signal` passes through a 2-flop synchroniser plus a history flop, all resetting to 0. A start is detected when the synchronised signal is 1 and the history flop is 0.
- A trigger held constantly high from reset therefore yields exactly one start.
- States: IDLE, DELAY, SEND.
- **IDLE:**
  - All outputs are 0, except `output_data_rate`, which holds its last value.
  - On a start: latch `rate_sel` into `output_data_rate`, load the delay counter, and go to DELAY.
- **DELAY:** counts START_DELAY cycles. On the last cycle:
  - if `in_valid`: assert `in_ready`, load the shift register, and go to SEND;
  - otherwise go to IDLE (underrun; no bits are sent).
- **SEND:**
  - `cur_bit` is shift_reg[0].
  - The phase counter toggles `clock_out` every SHIFT_HALF cycles. Its first half-period is high.
  - The bit counter runs `SYMBOL_CYCLES << rate` cycles per bit, then the register shifts right.
  - After DATA_WIDTH bits: if `in_valid`, pulse `in_ready`, reload, and continue with no gap. The phase wave is not restarted.
  - If `in_valid` is low at that point, go to IDLE.
- Starts detected during DELAY or SEND are ignored. They are not queued.
- `rate_sel` changes outside trigger detection have no effect until the next start.
- `reset` at any point returns the block to IDLE with all outputs 0 and `output_data_rate` = 0. A partially sent word is discarded.

## Timing
- The trigger is first sampled high at edge k. The start is detected in the cycle after edge k+2, and the state is DELAY from edge k+3.
- SEND is entered START_DELAY cycles after DELAY is entered. `in_ready` is high in the last DELAY cycle.
- Each bit occupies exactly SYMBOL_CYCLES·2^rate clock cycles.
- A word occupies DATA_WIDTH times that.
- The word-boundary `in_ready` pulse coincides with the last cycle of the final bit.
- `signal_into_switch` is registered, so it is glitch-free.
- The wave and phase are consistent within the same cycle; there is no extra pipeline stage between them.

## Structure
- `backscatter_pkg` holds:
  - the state enum (IDLE, DELAY, SEND);
  - `RATE_W = 2`;
  - a function computing cycles-per-bit from SYMBOL_CYCLES and the rate.
- Sub-module `trigger_sync_edge` contains the 2-flop synchroniser and the rising-edge detect, with async active-high reset.
- Remaining logic sits in one module: the FSM, three counters, and the shift register.

## Test plan
- **Constant-high trigger:**
  - Stimulus: trigger held at 1 from reset; DATA_WIDTH=8, SYMBOL_CYCLES=4, START_DELAY=10, rate_sel=0; one word 8'hA5 valid.
  - Required: exactly one packet of 32 SEND cycles. Phase is inverted in bits 0, 2, 5, 7. Then IDLE.
- **Rate 3:**
  - Stimulus: same word as the previous test with rate_sel=3.
  - Required: each bit lasts 32 cycles, `output_data_rate`=3, 256 SEND cycles in total.
- **Back-to-back words:**
  - Stimulus: two words, 8'hFF then 8'h00.
  - Required: `in_ready` pulses twice. `clock_out` is continuous across the boundary. `signal_into_switch` equals ~`clock_out` for 32 cycles, then `clock_out` for 32 cycles.
- **Underrun:**
  - Stimulus: `in_valid`=0 at the end of DELAY.
  - Required: no `in_ready`, `signal_into_switch` stays 0, `busy` falls after START_DELAY cycles.
- **Re-trigger:**
  - Stimulus: a second trigger pulse during SEND.
  - Required: ignored; a pulse after return to IDLE starts a new packet.
- **Reset mid-SEND:**
  - Stimulus: `reset` pulse at bit 3.
  - Required: all outputs 0 immediately (asynchronous reset) and state IDLE. The remaining word is never output. A new trigger after reset works normally.
